// File: rtl/osc_pkg.sv
// osc_pkg: shared sample types, sizes and capture FSM states for the scope display path
package osc_pkg;
    localparam int SAMPLE_W = 12;
    localparam int N_SAMPLES = 256;
    typedef logic [SAMPLE_W-1:0] sample_t;
    typedef sample_t sample_array_t [0:N_SAMPLES-1];
    typedef enum logic [1:0] {WAIT_TRIG, CAPTURE, PENDING, HOLD} capture_state_t;
endpackage

// File: rtl/capture_buffer_if.sv
// capture_buffer_if: sample/control inputs and committed-trace outputs of a capture buffer
interface capture_buffer_if #(parameter int SAMPLES = osc_pkg::N_SAMPLES);
    import osc_pkg::*;
    sample_t sample;
    logic    sample_valid;
    sample_t trigger_level;
    logic    trigger_falling;
    logic    auto_mode;
    logic    single_shot;
    logic    rearm;
    logic    vblnk;
    sample_t data_display [0:SAMPLES-1];
    logic    triggered;
    logic    forced;
    logic    frame_valid;
    logic    busy;
    modport master (
        output sample, sample_valid, trigger_level, trigger_falling, auto_mode, single_shot, rearm, vblnk,
        input  data_display, triggered, forced, frame_valid, busy
    );
    modport slave (
        input  sample, sample_valid, trigger_level, trigger_falling, auto_mode, single_shot, rearm, vblnk,
        output data_display, triggered, forced, frame_valid, busy
    );
endinterface

// File: rtl/capture_buffer_trigger_detect.sv
// trigger_detect: level/slope trigger with auto-timeout, held cleared whenever i_arm is low
module trigger_detect
    import osc_pkg::*;
#(
    parameter int AUTO_TIMEOUT = 4096
) (
    input  logic    clk,
    input  logic    rst,
    input  logic    i_arm,
    input  sample_t i_sample,
    input  logic    i_sample_valid,
    input  sample_t i_level,
    input  logic    i_falling,
    input  logic    i_auto_mode,
    output logic    o_trig,
    output logic    o_trig_forced
);
    sample_t     r_prev;
    logic        r_primed;
    logic [12:0] r_count;
    logic        w_edge;
    logic        w_timeout;

    // r_primed keeps the first sample after arming from ever triggering
    always_comb begin
        w_edge = r_primed && (i_falling ? (r_prev > i_level && i_sample <= i_level)
                                        : (r_prev < i_level && i_sample >= i_level));
        w_timeout = i_auto_mode && r_count == 13'(AUTO_TIMEOUT - 1);
        o_trig = i_arm && i_sample_valid && (w_edge || w_timeout);
        o_trig_forced = w_timeout && !w_edge;
    end

    always_ff @(posedge clk) begin
        if (rst || !i_arm) begin
            r_prev <= '0;
            r_primed <= 1'b0;
            r_count <= '0;
        end else if (i_sample_valid) begin
            r_prev <= i_sample;
            r_primed <= 1'b1;
            r_count <= r_count + 13'd1;
        end
    end
endmodule

// File: rtl/capture_buffer.sv
// capture_buffer: triggered 256-sample capture committed to the display array on vblank rise
module capture_buffer
    import osc_pkg::*;
#(
    parameter int SAMPLES = N_SAMPLES,
    parameter int AUTO_TIMEOUT = 4096
) (
    input  logic clk,
    input  logic rst,
    capture_buffer_if.slave bus
);
    localparam int PW = $clog2(SAMPLES);

    capture_state_t r_state;
    capture_state_t w_next;
    logic [PW-1:0]  r_wr_ptr;
    sample_t        r_cap_mem [0:SAMPLES-1];
    logic           r_vblnk_d;
    logic           w_trig;
    logic           w_trig_forced;
    logic           w_commit;
    logic           w_cap_wr;
    logic [PW-1:0]  w_wr_addr;

    trigger_detect #(.AUTO_TIMEOUT(AUTO_TIMEOUT)) u_trig (
        .clk           (clk),
        .rst           (rst),
        .i_arm         (r_state == WAIT_TRIG),
        .i_sample      (bus.sample),
        .i_sample_valid(bus.sample_valid),
        .i_level       (bus.trigger_level),
        .i_falling     (bus.trigger_falling),
        .i_auto_mode   (bus.auto_mode),
        .o_trig        (w_trig),
        .o_trig_forced (w_trig_forced)
    );

    always_comb begin
        w_next = r_state;
        w_commit = 1'b0;
        case (r_state)
            WAIT_TRIG: w_next = w_trig ? CAPTURE : WAIT_TRIG;
            CAPTURE:   w_next = (bus.sample_valid && r_wr_ptr == PW'(SAMPLES - 1)) ? PENDING : CAPTURE;
            PENDING: begin
                w_commit = bus.vblnk && !r_vblnk_d;
                w_next = w_commit ? (bus.single_shot ? HOLD : WAIT_TRIG) : PENDING;
            end
            HOLD:      w_next = (bus.rearm || !bus.single_shot) ? WAIT_TRIG : HOLD;
            default:   w_next = WAIT_TRIG;
        endcase
    end

    assign w_cap_wr  = (r_state == WAIT_TRIG) ? w_trig : (r_state == CAPTURE && bus.sample_valid);
    assign w_wr_addr = (r_state == CAPTURE) ? r_wr_ptr : PW'(0);
    assign bus.busy  = (r_state == WAIT_TRIG) || (r_state == CAPTURE);

    always_ff @(posedge clk) begin
        if (w_cap_wr)
            r_cap_mem[w_wr_addr] <= bus.sample;
    end

    // the whole trace moves in one edge so the drawing stage never sees a mix of two captures
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= WAIT_TRIG;
            r_wr_ptr <= '0;
            r_vblnk_d <= 1'b0;
            bus.triggered <= 1'b0;
            bus.forced <= 1'b0;
            bus.frame_valid <= 1'b0;
            bus.data_display <= '{default: '0};
        end else begin
            r_state <= w_next;
            r_vblnk_d <= bus.vblnk;
            bus.frame_valid <= w_commit;
            if (r_state == WAIT_TRIG && w_trig) begin
                r_wr_ptr <= PW'(1);
                bus.triggered <= 1'b1;
                bus.forced <= w_trig_forced;
            end else if (r_state == CAPTURE && bus.sample_valid) begin
                r_wr_ptr <= r_wr_ptr + PW'(1);
            end
            if (w_commit) begin
                bus.data_display <= r_cap_mem;
                bus.triggered <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_capture_buffer.sv
// tb_capture_buffer: randomized scoreboard bench for capture_buffer against a stream-scanning model
module tb_capture_buffer;
    import osc_pkg::*;
    localparam int S = N_SAMPLES;
    localparam int AT = 4096;
    localparam int MAXC = 6000;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    capture_buffer_if #(.SAMPLES(S)) bus ();
    capture_buffer #(.SAMPLES(S), .AUTO_TIMEOUT(AT)) dut (.clk(clk), .rst(rst), .bus(bus));

    logic [11:0] st_s [MAXC];
    logic        st_v [MAXC];
    logic        st_b [MAXC];
    logic        st_r [MAXC];
    int          n_cyc;
    logic [11:0] cfg_level;
    logic        cfg_fall, cfg_auto, cfg_single;

    int              exp_cyc [$];
    logic            exp_forced [$];
    logic [S*12-1:0] exp_data [$];
    logic [S*12-1:0] shadow = '0;
    int cur = -1;
    int checks = 0, passes = 0, unstable = 0, n_frames = 0, last_commit = -1;

    int              m_cyc, m_bad;
    logic            m_forced, prev_trig = 1'b0;
    logic [S*12-1:0] m_data;

    task automatic check(input string name, input longint act, input longint req);
        checks++;
        if (act == req) passes++;
        else $display("FAIL %s: got %0d expected %0d", name, act, req);
    endtask

    task automatic cfg(input logic [11:0] lvl, input logic fall, input logic auto_m, input logic single);
        cfg_level = lvl; cfg_fall = fall; cfg_auto = auto_m; cfg_single = single;
        bus.trigger_level = lvl; bus.trigger_falling = fall; bus.auto_mode = auto_m; bus.single_shot = single;
    endtask

    task automatic clear(input int n);
        n_cyc = n;
        for (int k = 0; k < MAXC; k++) begin
            st_s[k] = '0; st_v[k] = 1'b0; st_b[k] = 1'b0; st_r[k] = 1'b0;
        end
    endtask

    // Reference: scan the sample stream for a trigger, take the next S valid samples,
    // then commit on the first vblank rise strictly after the last captured sample.
    task automatic plan(input int start, output int first_end);
        int c, seen, got;
        logic [11:0] prv;
        logic primed, hit, frc, edge_ok;
        logic [S*12-1:0] win;
        c = start;
        first_end = -1;
        while (c < n_cyc) begin
            primed = 1'b0; hit = 1'b0; frc = 1'b0; seen = 0; got = 0; win = '0; prv = '0;
            while (c < n_cyc && !hit) begin
                if (st_v[c]) begin
                    edge_ok = primed && (cfg_fall ? (prv > cfg_level && st_s[c] <= cfg_level)
                                                  : (prv < cfg_level && st_s[c] >= cfg_level));
                    seen++;
                    hit = edge_ok || (cfg_auto && seen == AT);
                    frc = !edge_ok;
                    prv = st_s[c];
                    primed = 1'b1;
                end
                c++;
            end
            if (!hit) break;
            win[11:0] = prv;
            got = 1;
            while (c < n_cyc && got < S) begin
                if (st_v[c]) begin
                    win[got*12 +: 12] = st_s[c];
                    got++;
                end
                c++;
            end
            if (got < S) break;
            if (first_end < 0) first_end = c - 1;
            while (c < n_cyc && !(st_b[c] && !st_b[c-1])) c++;
            if (c >= n_cyc) break;
            exp_cyc.push_back(c);
            exp_forced.push_back(frc);
            exp_data.push_back(win);
            if (cfg_single) break;
            c++;
        end
    endtask

    task automatic run();
        for (int k = 0; k < n_cyc; k++) begin
            @(negedge clk);
            bus.sample = st_s[k]; bus.sample_valid = st_v[k]; bus.vblnk = st_b[k]; bus.rearm = st_r[k];
            cur = k;
        end
        @(negedge clk);
        bus.sample_valid = 1'b0; bus.vblnk = 1'b0; bus.rearm = 1'b0;
        cur = -1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        shadow = '0;
        rst = 1'b0;
    endtask

    task automatic reset_checks();
        int nz;
        nz = 0;
        for (int i = 0; i < S; i++) if (bus.data_display[i] != 12'd0) nz++;
        check("rst_display_nonzero", nz, 0);
        check("rst_busy", bus.busy, 1);
        check("rst_triggered", bus.triggered, 0);
        check("rst_forced", bus.forced, 0);
        check("rst_frame_valid", bus.frame_valid, 0);
    endtask

    task automatic go(input int start, input bit with_rst);
        int e;
        if (with_rst) do_reset();
        exp_cyc.delete(); exp_forced.delete(); exp_data.delete();
        st_b[0] = 1'b0;
        st_b[n_cyc-1] = 1'b0;
        plan(start, e);
        run();
        check("commits_outstanding", exp_cyc.size(), 0);
        check("display_stable", unstable, 0);
    endtask

    always @(posedge clk) begin
        #1;
        if (rst) begin
            prev_trig = 1'b0;
        end else if (bus.frame_valid) begin
            n_frames++;
            last_commit = cur;
            if (exp_cyc.size() == 0) begin
                check("spurious_frame", bus.frame_valid, 0);
            end else begin
                m_cyc = exp_cyc.pop_front();
                m_forced = exp_forced.pop_front();
                m_data = exp_data.pop_front();
                m_bad = 0;
                for (int i = 0; i < S; i++) if (bus.data_display[i] !== m_data[i*12 +: 12]) m_bad++;
                check("commit_cycle", cur, m_cyc);
                check("commit_forced", bus.forced, m_forced);
                check("commit_bad_entries", m_bad, 0);
                check("triggered_before_commit", prev_trig, 1);
                check("triggered_cleared", bus.triggered, 0);
                shadow = m_data;
            end
            prev_trig = bus.triggered;
        end else begin
            for (int i = 0; i < S; i++) if (bus.data_display[i] !== shadow[i*12 +: 12]) unstable++;
            prev_trig = bus.triggered;
        end
    end

    initial begin
        int e, f0, bad;
        logic [11:0] s;
        bus.sample = '0; bus.sample_valid = 1'b0; bus.rearm = 1'b0; bus.vblnk = 1'b0;
        cfg(12'd0, 1'b0, 1'b0, 1'b0);
        do_reset();
        reset_checks();

        // rising ramp
        cfg(12'd2048, 1'b0, 1'b0, 1'b0);
        clear(600);
        for (int k = 0; k < 600; k++) begin
            st_s[k] = 12'(k * 16); st_v[k] = 1'b1; st_b[k] = (k >= 450 && k < 460);
            st_r[k] = ($urandom_range(0, 7) == 0);
        end
        go(0, 1);
        check("rise_first", bus.data_display[0], 2048);
        check("rise_last", bus.data_display[255], 2032);
        check("rise_forced", bus.forced, 0);

        // falling ramp; invalid cycles carry a value that would trigger if not ignored
        cfg(12'd1000, 1'b1, 1'b0, 1'b0);
        clear(1300);
        e = 0;
        for (int k = 0; k < 1300; k++) begin
            st_v[k] = (k % 4 != 3);
            st_s[k] = st_v[k] ? 12'(4095 - 7 * e) : 12'd0;
            if (st_v[k]) e++;
            st_b[k] = (k >= 1150 && k < 1170);
        end
        go(0, 1);
        check("fall_first", bus.data_display[0], 994);

        // auto timeout on a flat input
        cfg(12'd2048, 1'b0, 1'b1, 1'b0);
        clear(4500);
        for (int k = 0; k < 4500; k++) begin
            st_s[k] = 12'd500; st_v[k] = 1'b1; st_b[k] = (k >= 4400 && k < 4420);
        end
        f0 = n_frames;
        go(0, 1);
        check("auto_frames", n_frames - f0, 1);
        check("auto_forced", bus.forced, 1);
        bad = 0;
        for (int i = 0; i < S; i++) if (bus.data_display[i] != 12'd500) bad++;
        check("auto_entries_not_500", bad, 0);

        // same input with auto off never commits
        cfg(12'd2048, 1'b0, 1'b0, 1'b0);
        clear(4500);
        for (int k = 0; k < 4500; k++) begin
            st_s[k] = 12'd500; st_v[k] = 1'b1; st_b[k] = (k % 500) >= 480;
        end
        f0 = n_frames;
        go(0, 1);
        check("noauto_frames", n_frames - f0, 0);
        check("noauto_triggered", bus.triggered, 0);

        // tear-free: vblank rise on the last write is skipped, next one 2000 cycles later
        cfg(12'd2000, 1'b0, 1'b0, 1'b0);
        clear(MAXC);
        for (int k = 0; k < MAXC; k++) begin
            st_s[k] = 12'($urandom_range(0, 4095)); st_v[k] = ($urandom_range(0, 1) == 1);
        end
        st_s[10] = 12'd0; st_v[10] = 1'b1; st_s[11] = 12'd4095; st_v[11] = 1'b1;
        exp_cyc.delete(); exp_forced.delete(); exp_data.delete();
        plan(0, e);
        n_cyc = e + 2100;
        for (int k = e; k < e + 6; k++) st_b[k] = 1'b1;
        for (int k = e + 2000; k < e + 2010; k++) st_b[k] = 1'b1;
        go(0, 1);
        check("tear_commit_cycle", last_commit, e + 2000);

        // single shot holds, rearm restarts
        cfg(12'd2048, 1'b0, 1'b0, 1'b1);
        clear(3000);
        for (int k = 0; k < 3000; k++) begin
            st_s[k] = 12'($urandom_range(0, 4095)); st_v[k] = ($urandom_range(0, 9) < 6); st_b[k] = (k % 300) >= 280;
        end
        f0 = n_frames;
        go(0, 1);
        check("single_frames", n_frames - f0, 1);
        check("hold_busy", bus.busy, 0);
        clear(3000);
        for (int k = 0; k < 3000; k++) begin
            st_s[k] = 12'($urandom_range(0, 4095)); st_v[k] = ($urandom_range(0, 9) < 6); st_b[k] = (k % 300) >= 280;
        end
        st_r[0] = 1'b1;
        go(1, 0);
        check("rearm_frames", n_frames - f0, 2);
        check("rearm_hold_busy", bus.busy, 0);

        // reset after 100 captured samples
        cfg(12'd2000, 1'b0, 1'b0, 1'b0);
        clear(111);
        for (int k = 0; k < 111; k++) begin
            st_v[k] = 1'b1; st_s[k] = (k < 11) ? 12'd0 : (k == 11) ? 12'd4095 : 12'($urandom_range(0, 4095));
        end
        go(0, 1);
        check("mid_triggered", bus.triggered, 1);
        check("mid_busy", bus.busy, 1);
        do_reset();
        reset_checks();
        clear(450);
        for (int k = 0; k < 450; k++) begin
            st_v[k] = 1'b1; st_s[k] = (k < 5) ? 12'd100 : (k == 5) ? 12'd3000 : 12'($urandom_range(0, 4095));
            st_b[k] = (k >= 400 && k < 420);
        end
        go(0, 0);
        check("restart_first", bus.data_display[0], 3000);

        // randomized continuous runs
        for (int r = 0; r < 2; r++) begin
            cfg(12'($urandom_range(800, 3200)), 1'($urandom_range(0, 1)), 1'b0, 1'b0);
            clear(5000);
            s = 12'($urandom_range(0, 4095));
            for (int k = 0; k < 5000; k++) begin
                s = 12'(int'(s) + int'($urandom_range(0, 300)) - 150);
                st_s[k] = s; st_v[k] = ($urandom_range(0, 9) < 7); st_b[k] = (k % 450) >= 420;
                st_r[k] = ($urandom_range(0, 15) == 0);
            end
            go(0, 1);
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
